// File: rtl/fpu_result_sequencer.sv
// In-order result sequencer: a tag FIFO of issued opcodes, per-channel capture
// slots for out-of-order unit results, and a valid/ready output register.

module fpu_rs_slot #(
  parameter int DW = 32,
  parameter int FW = 5,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          res_valid_i,
  input  logic [DW-1:0] res_data_i,
  input  logic [FW-1:0] res_flags_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic          slot_v_o,
  output logic [DW-1:0] slot_data_o,
  output logic [FW-1:0] slot_flags_o,
  output logic          orphan_o
);
  logic          v_q;
  logic [DW-1:0] data_q;
  logic [FW-1:0] flags_q;
  logic [CW-1:0] outst_q, outst_d;
  logic          cap;

  // Orphan check uses the registered count, so a same-cycle issue does not legitimise a result.
  assign cap      = res_valid_i && !v_q && (outst_q != '0);
  assign orphan_o = res_valid_i && !v_q && (outst_q == '0);
  assign outst_d  = outst_q + CW'(inc_i) - CW'(dec_i);

  assign slot_v_o     = v_q;
  assign slot_data_o  = data_q;
  assign slot_flags_o = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
      outst_q <= '0;
    end else begin
      // dec_i implies v_q, which blocks cap, so the two never collide
      if (cap) begin
        v_q     <= 1'b1;
        data_q  <= res_data_i;
        flags_q <= res_flags_i;
      end else if (dec_i) begin
        v_q <= 1'b0;
      end
      outst_q <= outst_d;
    end
  end
endmodule

module fpu_result_sequencer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int OP_WIDTH   = 2,
  parameter  int FLAG_WIDTH = 5,
  parameter  int TAG_DEPTH  = 4,
  localparam int NUM_CH     = 2**OP_WIDTH,
  localparam int CNT_W      = $clog2(TAG_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  input  logic [OP_WIDTH-1:0]          issue_opcode,
  output logic                         issue_ready,
  input  logic [NUM_CH-1:0]            res_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] res_data,
  input  logic [NUM_CH*FLAG_WIDTH-1:0] res_flags,
  output logic [NUM_CH-1:0]            res_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [FLAG_WIDTH-1:0]        out_flags,
  output logic [OP_WIDTH-1:0]          out_opcode,
  output logic [CNT_W-1:0]             pending_count,
  output logic                         err_orphan
);
  localparam int PW = $clog2(TAG_DEPTH);

  logic [TAG_DEPTH-1:0][OP_WIDTH-1:0] tag_q;
  logic [PW-1:0]                      wr_q, rd_q;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic                               push, fire, empty;
  logic [OP_WIDTH-1:0]                head_op;

  logic [NUM_CH-1:0]                  slot_v, orphan, inc, dec;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  slot_data;
  logic [NUM_CH-1:0][FLAG_WIDTH-1:0]  slot_flags;

  logic                               out_valid_q, err_q;
  logic [DATA_WIDTH-1:0]              out_data_q;
  logic [FLAG_WIDTH-1:0]              out_flags_q;
  logic [OP_WIDTH-1:0]                out_op_q;

  // Full FIFO stays full this cycle even if it pops: ready is registered-state only.
  assign issue_ready = count_q < CNT_W'(TAG_DEPTH);
  assign push        = issue_valid && issue_ready;
  assign empty       = count_q == '0;
  assign head_op     = tag_q[rd_q];
  assign fire        = !empty && slot_v[head_op] && (!out_valid_q || out_ready);
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(fire);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign inc[c]       = push && (issue_opcode == OP_WIDTH'(c));
    assign dec[c]       = fire && (head_op == OP_WIDTH'(c));
    assign res_ready[c] = !slot_v[c];

    fpu_rs_slot #(.DW(DATA_WIDTH), .FW(FLAG_WIDTH), .CW(CNT_W)) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .res_valid_i  (res_valid[c]),
      .res_data_i   (res_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .res_flags_i  (res_flags[c*FLAG_WIDTH +: FLAG_WIDTH]),
      .inc_i        (inc[c]),
      .dec_i        (dec[c]),
      .slot_v_o     (slot_v[c]),
      .slot_data_o  (slot_data[c]),
      .slot_flags_o (slot_flags[c]),
      .orphan_o     (orphan[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tag_q[wr_q] <= issue_opcode;
        wr_q        <= wr_q + PW'(1);
      end
      if (fire) rd_q <= rd_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      out_op_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= slot_data[head_op];
        out_flags_q <= slot_flags[head_op];
        out_op_q    <= head_op;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      err_q <= err_q | (|orphan);
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_flags     = out_flags_q;
  assign out_opcode    = out_op_q;
  assign pending_count = count_q;
  assign err_orphan    = err_q;
endmodule
